// File: rtl/data_memory_block_pkg.sv
// dmem_pkg: widths, latency default and FSM encoding shared by the data cache and its backing memory.
package dmem_pkg;
  localparam int DMEM_ADDR_W  = 6;
  localparam int DMEM_DATA_W  = 32;
  localparam int DMEM_LATENCY = 5;
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACCESS   = 2'b01,
    COMPLETE = 2'b10
  } state_t;
endpackage

// File: rtl/data_memory_block_if.sv
// data_memory_block_if: cache-to-memory busy-wait port; master is the cache, slave is the memory.
interface data_memory_block_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
);
  logic              Mem_Read;
  logic              Mem_Write;
  logic [ADDR_W-1:0] Mem_Address;
  logic [DATA_W-1:0] Mem_WriteData;
  logic [DATA_W-1:0] Mem_ReadData;
  logic              Mem_BusyWait;
  modport master (output Mem_Read, Mem_Write, Mem_Address, Mem_WriteData, input Mem_ReadData, Mem_BusyWait);
  modport slave (input Mem_Read, Mem_Write, Mem_Address, Mem_WriteData, output Mem_ReadData, Mem_BusyWait);
endinterface

// File: rtl/data_memory_block_mem_latency_counter.sv
// mem_latency_counter: loadable down-counter flagging when the modelled access latency has elapsed.
module mem_latency_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);
  logic [3:0] count_q, count_d;
  always_comb count_d = load ? load_val : dec ? count_q - 4'd1 : count_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else count_q <= count_d;
  assign zero = count_q == '0;
endmodule

// File: rtl/data_memory_block.sv
// data_memory_block: 64-word block memory behind the data cache with fixed multi-cycle latency
// and a busy-wait handshake; requests are latched at capture so the requester may change them freely.
module data_memory_block
  import dmem_pkg::*;
#(
  parameter int LATENCY = DMEM_LATENCY,
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int DATA_W  = DMEM_DATA_W
) (
  input logic Clk,
  input logic Reset,
  data_memory_block_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] LOAD_VAL = 4'(LATENCY - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] op_addr_q, op_addr_d;
  logic [DATA_W-1:0] op_data_q, op_data_d;
  logic              op_is_write_q, op_is_write_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic req, capture, zero, fire;
  assign req     = bus.Mem_Read | bus.Mem_Write;
  assign capture = state_q == IDLE && req;
  assign fire    = state_q == ACCESS && zero;
  mem_latency_counter u_cnt (
    .clk     (Clk),
    .rst     (Reset),
    .load    (capture),
    .load_val(LOAD_VAL),
    .dec     (state_q == ACCESS && !zero),
    .zero    (zero)
  );
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE   ? (req ? ACCESS : IDLE) :
              state_q == ACCESS ? (zero ? COMPLETE : ACCESS) : IDLE;
  always_comb bus.Mem_BusyWait = state_q == IDLE ? req : state_q == ACCESS;
  assign bus.Mem_ReadData = rd_data_q;
  // Write wins when both requests are raised together.
  always_comb begin
    op_addr_d     = capture ? bus.Mem_Address : op_addr_q;
    op_data_d     = capture ? bus.Mem_WriteData : op_data_q;
    op_is_write_d = capture ? bus.Mem_Write : op_is_write_q;
    rd_data_d     = fire && !op_is_write_q ? mem_q[op_addr_q] : rd_data_q;
    mem_d         = mem_q;
    if (fire && op_is_write_q) mem_d[op_addr_q] = op_data_q;
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      op_addr_q     <= '0;
      op_data_q     <= '0;
      op_is_write_q <= 1'b0;
      rd_data_q     <= '0;
      mem_q         <= '{default: '0};
    end else begin
      op_addr_q     <= op_addr_d;
      op_data_q     <= op_data_d;
      op_is_write_q <= op_is_write_d;
      rd_data_q     <= rd_data_d;
      mem_q         <= mem_d;
    end
endmodule
